// File: rtl/pwm_reg_write_arbiter.sv
// Round-robin write arbiter for the PWM config bank: requesters A/B write a shadow bank,
// committed to regs_out only on period_end so mid-period changes never glitch the PWM.
// Ports: a_/b_ valid/ready/addr/data write channels, period_end commit strobe,
// regs_out active bank, pending_any, commit_pulse and err_addr status pulses.
module pwm_reg_write_arbiter #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [ADDR_W-1:0]            a_addr,
  input  logic [DATA_W-1:0]            a_data,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [ADDR_W-1:0]            b_addr,
  input  logic [DATA_W-1:0]            b_data,
  input  logic                         period_end,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         pending_any,
  output logic                         commit_pulse,
  output logic                         err_addr
);

  // One extra bit so the range check never truncates NUM_REGS.
  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic                               prio_b;
  logic [NUM_REGS-1:0][DATA_W-1:0]    regs;
  logic [NUM_REGS-1:0][DATA_W-1:0]    pend;
  logic [NUM_REGS-1:0]                pbit;
  logic                               grant;
  logic                               in_range;
  logic [ADDR_W-1:0]                  waddr;
  logic [DATA_W-1:0]                  wdata;

  // prio_b set means B was not granted most recently and wins a tie.
  assign a_ready = !rst && a_valid && (!b_valid || !prio_b);
  assign b_ready = !rst && b_valid && (!a_valid || prio_b);

  assign grant    = a_ready | b_ready;
  assign waddr    = b_ready ? b_addr : a_addr;
  assign wdata    = b_ready ? b_data : a_data;
  assign in_range = {1'b0, waddr} < NREGS;

  assign regs_out    = regs;
  assign pending_any = |pbit;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b       <= 1'b0;
      regs         <= '0;
      pend         <= '0;
      pbit         <= '0;
      commit_pulse <= 1'b0;
      err_addr     <= 1'b0;
    end else begin
      commit_pulse <= period_end && (|pbit);
      err_addr     <= grant && !in_range;
      if (a_ready)
        prio_b <= 1'b1;
      else if (b_ready)
        prio_b <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (period_end && pbit[i]) begin
          regs[i] <= pend[i];
          pbit[i] <= 1'b0;
        end
        // Later assignment wins: a write in the commit cycle stays pending.
        if (grant && in_range && waddr == ADDR_W'(i)) begin
          pend[i] <= wdata;
          pbit[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_reg_write_arbiter.sv
// Scoreboard bench for pwm_reg_write_arbiter: directed writes push expected grants,
// commits and address errors; a negedge monitor pops and compares them.
module tb_pwm_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, period_end;
  logic        a_ready, b_ready;
  logic [6:0]  a_addr, b_addr;
  logic [7:0]  a_data, b_data;
  logic [39:0] regs_out;
  logic        pending_any, commit_pulse, err_addr;

  int checks = 0;
  int fails  = 0;

  byte         grant_q[$];
  logic [40:0] commit_q[$];
  int          err_q[$];

  always #5 clk = ~clk;

  pwm_reg_write_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .period_end(period_end), .regs_out(regs_out),
    .pending_any(pending_any), .commit_pulse(commit_pulse), .err_addr(err_addr)
  );

  // Monitor: compares every DUT output event against the scoreboard.
  always @(negedge clk) begin
    byte         eg, gg;
    logic [40:0] ec;
    if (a_ready && b_ready) begin
      checks++; fails++;
      $display("FAIL both_ready got a=%0b b=%0b need one", a_ready, b_ready);
    end
    if ((a_ready && !a_valid) || (b_ready && !b_valid)) begin
      checks++; fails++;
      $display("FAIL ready_wo_valid got ready=%0b%0b need 00", a_ready, b_ready);
    end
    if (a_ready || b_ready) begin
      checks++;
      gg = a_ready ? "A" : "B";
      if (grant_q.size() == 0) begin
        fails++;
        $display("FAIL grant got %c need none", gg);
      end else begin
        eg = grant_q.pop_front();
        if (gg != eg) begin
          fails++;
          $display("FAIL grant got %c need %c", gg, eg);
        end
      end
    end
    if (commit_pulse) begin
      checks++;
      if (commit_q.size() == 0) begin
        fails++;
        $display("FAIL commit got pulse need none");
      end else begin
        ec = commit_q.pop_front();
        if ({regs_out, pending_any} != ec) begin
          fails++;
          $display("FAIL commit got %h/%0b need %h/%0b",
                   regs_out, pending_any, ec[40:1], ec[0]);
        end
      end
    end
    if (err_addr) begin
      checks++;
      if (err_q.size() == 0) begin
        fails++;
        $display("FAIL err_addr got pulse need none");
      end else begin
        void'(err_q.pop_front());
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h need %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [6:0] aa, input logic [7:0] ad,
                       input logic bv, input logic [6:0] ba, input logic [7:0] bd,
                       input logic pe);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    period_end = pe;
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0; period_end = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Arbitration vectors: both held valid, data advances only after acceptance.
  logic [7:0] arb_a[6] = '{8'h11, 8'h12, 8'h12, 8'h13, 8'h13, 8'h14};
  logic [7:0] arb_b[6] = '{8'h22, 8'h22, 8'h23, 8'h23, 8'h24, 8'h24};

  initial begin
    rst = 1'b1;
    a_valid = 0; b_valid = 0; period_end = 0;
    a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_regs", 64'(regs_out), 64'h0);
    check("rst_pend", 64'(pending_any), 64'h0);
    check("rst_commit", 64'(commit_pulse), 64'h0);
    check("rst_err", 64'(err_addr), 64'h0);

    // Write held in shadow until period_end.
    grant_q.push_back("A");
    drive(1, 7'd0, 8'hFF, 0, 0, 0, 0);
    idle(1);
    check("t1_reg0_held", 64'(regs_out), 64'h0);
    check("t1_pend", 64'(pending_any), 64'h1);
    commit_q.push_back({40'h00_00_00_00_FF, 1'b0});
    drive(0, 0, 0, 0, 0, 0, 1);
    check("t1_pend_clr", 64'(pending_any), 64'h0);
    idle(2);

    // Round-robin from a fresh reset: A wins first tie, then alternates.
    do_reset();
    check("t2_rst_regs", 64'(regs_out), 64'h0);
    for (int i = 0; i < 6; i++) grant_q.push_back((i % 2 == 0) ? "A" : "B");
    for (int i = 0; i < 6; i++) drive(1, 7'd1, arb_a[i], 1, 7'd2, arb_b[i], 0);
    commit_q.push_back({40'h00_00_24_13_00, 1'b0});
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Last write to the same register wins.
    grant_q.push_back("A");
    grant_q.push_back("B");
    drive(1, 7'd3, 8'h0F, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 7'd3, 8'hF0, 0);
    commit_q.push_back({40'h00_F0_24_13_00, 1'b0});
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Out-of-range addresses are accepted and dropped.
    grant_q.push_back("A");
    grant_q.push_back("A");
    err_q.push_back(1);
    err_q.push_back(1);
    drive(1, 7'd5, 8'hEE, 0, 0, 0, 0);
    drive(1, 7'h7F, 8'hDD, 0, 0, 0, 0);
    check("t4_pend", 64'(pending_any), 64'h0);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    check("t4_regs", 64'(regs_out), 64'h00_F0_24_13_00);
    check("t4_pend2", 64'(pending_any), 64'h0);

    // Write coinciding with commit stays pending for the next period.
    grant_q.push_back("B");
    grant_q.push_back("B");
    drive(0, 0, 0, 1, 7'd4, 8'h55, 0);
    commit_q.push_back({40'h55_F0_24_13_00, 1'b1});
    drive(0, 0, 0, 1, 7'd4, 8'hAA, 1);
    idle(1);
    check("t5_pend", 64'(pending_any), 64'h1);
    commit_q.push_back({40'hAA_F0_24_13_00, 1'b0});
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Reset discards pending writes; A wins the first tie afterwards.
    for (int i = 0; i < 5; i++) begin
      grant_q.push_back("A");
      drive(1, 7'(i), 8'(i + 1), 0, 0, 0, 0);
    end
    check("t6_pend_pre", 64'(pending_any), 64'h1);
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    check("t6_regs", 64'(regs_out), 64'h0);
    check("t6_pend", 64'(pending_any), 64'h0);
    check("t6_commit", 64'(commit_pulse), 64'h0);
    grant_q.push_back("A");
    grant_q.push_back("B");
    drive(1, 7'd0, 8'h77, 1, 7'd1, 8'h88, 0);
    drive(0, 0, 0, 1, 7'd1, 8'h88, 0);
    commit_q.push_back({40'h00_00_00_88_77, 1'b0});
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(3);

    check("grant_q_empty", 64'(grant_q.size()), 64'h0);
    check("commit_q_empty", 64'(commit_q.size()), 64'h0);
    check("err_q_empty", 64'(err_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
